// File: rtl/cd_tx_fetch.sv
// +----------------------------------------------------------------------------+
// | cd_tx_fetch: drains committed frame-RAM pages into a valid/ready byte      |
// | stream for the TX serializer, with restart, flush and length checking.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module cd_tx_fetch #(
  parameter int A_WIDTH  = 8,
  parameter int MAX_DATA = 250
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               unread,
  output logic [A_WIDTH-1:0] rd_addr,
  output logic               rd_en,
  input  logic [7:0]         rd_byte,
  input  logic [7:0]         rd_flags,
  output logic               rd_done,
  output logic               rd_done_all,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  output logic               tx_first,
  output logic               tx_last,
  input  logic               tx_ready,
  input  logic               restart,
  input  logic               flush,
  output logic [7:0]         frame_flags,
  output logic               len_err,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_LEN  = 3'd1,
    S_CAP_LEN = 3'd2,
    S_RD      = 3'd3,
    S_CAP     = 3'd4,
    S_HOLD    = 3'd5,
    S_DONE    = 3'd6,
    S_FLUSH   = 3'd7
  } state_t;

  localparam logic [8:0]         C_MAX_LEN  = 9'(MAX_DATA);
  localparam logic [A_WIDTH-1:0] C_LEN_ADDR = A_WIDTH'(2);

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] idx_q, idx_d;
  logic [A_WIDTH-1:0] last_idx_q, last_idx_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               tx_first_q, tx_first_d;
  logic               tx_last_q, tx_last_d;
  logic [7:0]         frame_flags_q, frame_flags_d;
  logic [A_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic               rd_en_q, rd_en_d;
  logic               done_q, done_d;
  logic               done_all_q, done_all_d;
  logic               busy_q, busy_d;
  logic               w_len_bad;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    last_idx_d    = last_idx_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    tx_first_d    = tx_first_q;
    tx_last_d     = tx_last_q;
    frame_flags_d = frame_flags_q;
    w_len_bad     = 1'b0;

    // Flush outranks restart and any handshake in the same cycle.
    if (flush) begin
      state_d    = S_FLUSH;
      tx_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE:   if (unread) state_d = S_RD_LEN;
        S_RD_LEN: state_d = S_CAP_LEN;
        S_CAP_LEN: begin
          frame_flags_d = rd_flags;
          if ({1'b0, rd_byte} > C_MAX_LEN) begin
            w_len_bad = 1'b1;
            state_d   = S_IDLE;
          end else begin
            last_idx_d = A_WIDTH'({1'b0, rd_byte} + 9'd4);
            idx_d      = '0;
            state_d    = S_RD;
          end
        end
        S_RD: begin
          if (restart) idx_d = '0;
          else         state_d = S_CAP;
        end
        S_CAP: begin
          if (restart) begin
            idx_d   = '0;
            state_d = S_RD;
          end else begin
            tx_data_d  = rd_byte;
            tx_first_d = (idx_q == '0);
            tx_last_d  = (idx_q == last_idx_q);
            tx_valid_d = 1'b1;
            state_d    = S_HOLD;
          end
        end
        S_HOLD: begin
          if (restart) begin
            tx_valid_d = 1'b0;
            idx_d      = '0;
            state_d    = S_RD;
          end else if (tx_ready) begin
            tx_valid_d = 1'b0;
            if (tx_last_q) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_RD;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_FLUSH: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // RAM-side strobes follow the next state so they line up with RD_LEN/RD/DONE/FLUSH.
    rd_en_d    = (state_d == S_RD_LEN) || (state_d == S_RD);
    rd_addr_d  = (state_d == S_RD)     ? idx_d :
                 (state_d == S_RD_LEN) ? C_LEN_ADDR : '0;
    done_d     = (state_d == S_DONE);
    done_all_d = (state_d == S_FLUSH);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      last_idx_q    <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      tx_first_q    <= 1'b0;
      tx_last_q     <= 1'b0;
      frame_flags_q <= '0;
      rd_addr_q     <= '0;
      rd_en_q       <= 1'b0;
      done_q        <= 1'b0;
      done_all_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      last_idx_q    <= last_idx_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      tx_first_q    <= tx_first_d;
      tx_last_q     <= tx_last_d;
      frame_flags_q <= frame_flags_d;
      rd_addr_q     <= rd_addr_d;
      rd_en_q       <= rd_en_d;
      done_q        <= done_d;
      done_all_q    <= done_all_d;
      busy_q        <= busy_d;
    end
  end

  // A bad length releases the page while still in CAP_LEN so IDLE sees the updated unread.
  assign rd_done     = done_q | w_len_bad;
  assign len_err     = w_len_bad;
  assign rd_done_all = done_all_q;
  assign rd_addr     = rd_addr_q;
  assign rd_en       = rd_en_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign tx_first    = tx_first_q;
  assign tx_last     = tx_last_q;
  assign frame_flags = frame_flags_q;
  assign busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_cd_tx_fetch.sv
// +----------------------------------------------------------------------------+
// | tb_cd_tx_fetch: directed bench with a paged frame-RAM model for cd_tx_fetch|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cd_tx_fetch;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       unread;
  logic [7:0] rd_addr;
  logic       rd_en;
  logic [7:0] rd_byte;
  logic [7:0] rd_flags;
  logic       rd_done, rd_done_all;
  logic [7:0] tx_data;
  logic       tx_valid, tx_first, tx_last;
  logic       tx_ready, restart, flush;
  logic [7:0] frame_flags;
  logic       len_err, busy;

  int checks   = 0;
  int failures = 0;

  cd_tx_fetch #(.A_WIDTH(8), .MAX_DATA(250)) dut (
    .clk(clk), .reset_n(reset_n), .unread(unread),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_byte(rd_byte), .rd_flags(rd_flags),
    .rd_done(rd_done), .rd_done_all(rd_done_all),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_first(tx_first), .tx_last(tx_last),
    .tx_ready(tx_ready), .restart(restart), .flush(flush),
    .frame_flags(frame_flags), .len_err(len_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Paged RAM model: four page slots in a ring, registered read port.
  logic [7:0] mem [4][256];
  logic [7:0] pflags [4];
  int head = 0;
  int tail = 0;
  assign unread = (head != tail);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head     <= tail;
      rd_byte  <= 8'h00;
      rd_flags <= 8'h00;
    end else begin
      if (rd_en) begin
        rd_byte  <= mem[head % 4][rd_addr];
        rd_flags <= pflags[head % 4];
      end
      if (rd_done_all)  head <= tail;
      else if (rd_done) head <= head + 1;
    end
  end

  // Stream monitor: {first,last,data} of every accepted byte plus pulse counters.
  logic [9:0] got_q [$];
  logic [9:0] exp_q [$];
  logic [7:0] flg_q [$];
  int n_done = 0, n_all = 0, n_lenerr = 0, n_both = 0, n_valid = 0;

  always @(posedge clk) begin
    if (reset_n) begin
      if (tx_valid && tx_ready && !restart && !flush) begin
        got_q.push_back({tx_first, tx_last, tx_data});
        if (tx_first) flg_q.push_back(frame_flags);
      end
      if (rd_done)            n_done   <= n_done + 1;
      if (rd_done_all)        n_all    <= n_all + 1;
      if (len_err)            n_lenerr <= n_lenerr + 1;
      if (len_err && rd_done) n_both   <= n_both + 1;
      if (tx_valid)           n_valid  <= n_valid + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] frame_byte(input logic [7:0] src, input logic [7:0] dst,
                                            input logic [7:0] len, input logic [7:0] c0,
                                            input logic [7:0] c1, input int k);
    if (k == 0) return src;
    if (k == 1) return dst;
    if (k == 2) return len;
    if (k == int'(len) + 3) return c0;
    if (k == int'(len) + 4) return c1;
    return 8'(8'h30 + k);
  endfunction

  task automatic load_page(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len,
                           input logic [7:0] flg, input logic [7:0] c0, input logic [7:0] c1);
    for (int k = 0; k < int'(len) + 5; k++) mem[tail % 4][k] = frame_byte(src, dst, len, c0, c1, k);
    pflags[tail % 4] = flg;
    tail = tail + 1;
  endtask

  // Queue the first n stream entries a frame should produce.
  task automatic push_exp(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len,
                          input logic [7:0] c0, input logic [7:0] c1, input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back({(k == 0), (k == int'(len) + 4), frame_byte(src, dst, len, c0, c1, k)});
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), {22'd0, got_q[i]}, {22'd0, exp_q[i]});
  endtask

  task automatic clear_logs();
    got_q.delete();
    exp_q.delete();
    flg_q.delete();
  endtask

  // Run until the engine is idle with nothing pending; checks tx_data holds while stalled.
  task automatic run_frames(input int budget, input bit toggle);
    logic       stall;
    logic [7:0] pd;
    int         n;
    stall = 1'b0;
    pd    = 8'h00;
    n     = 0;
    do begin
      @(negedge clk);
      n++;
      if (stall && tx_valid) chk("hold_data", tx_data, pd);
      tx_ready = toggle ? ~tx_ready : 1'b1;
      stall    = tx_valid && !tx_ready;
      pd       = tx_data;
    end while ((busy || unread) && n < budget);
    chk("run_timeout", (n < budget), 1);
    tx_ready = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!tx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (n < 200), 1);
  endtask

  int base_done, base_all, base_valid, n;

  initial begin
    reset_n  = 1'b0;
    tx_ready = 1'b1;
    restart  = 1'b0;
    flush    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_done", rd_done, 0);
    chk("rst_frame_flags", frame_flags, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // len=0 frame with the serializer always ready
    clear_logs();
    base_done = n_done;
    load_page(8'hA1, 8'hB2, 8'd0, 8'h5A, 8'hC3, 8'hD4);
    push_exp(8'hA1, 8'hB2, 8'd0, 8'hC3, 8'hD4, 5);
    run_frames(400, 1'b0);
    check_stream("len0");
    chk("len0_flags", frame_flags, 8'h5A);
    chk("len0_rd_done", n_done - base_done, 1);

    // len=3 frame with tx_ready toggling every cycle
    clear_logs();
    base_done = n_done;
    load_page(8'h10, 8'h20, 8'd3, 8'h33, 8'hE1, 8'hE2);
    push_exp(8'h10, 8'h20, 8'd3, 8'hE1, 8'hE2, 8);
    run_frames(400, 1'b1);
    check_stream("len3");
    chk("len3_rd_done", n_done - base_done, 1);

    // len=251 exceeds MAX_DATA: dropped without any stream activity
    clear_logs();
    base_done  = n_done;
    base_valid = n_valid;
    load_page(8'h01, 8'h02, 8'd251, 8'h44, 8'h00, 8'h00);
    run_frames(400, 1'b0);
    chk("lenerr_no_valid", n_valid - base_valid, 0);
    chk("lenerr_pulses", n_lenerr, 1);
    chk("lenerr_same_cycle", n_both, 1);
    chk("lenerr_rd_done", n_done - base_done, 1);
    chk("lenerr_busy", busy, 0);

    // restart while byte 4 of a len=4 frame is presented
    clear_logs();
    base_done = n_done;
    load_page(8'h55, 8'h66, 8'd4, 8'h77, 8'hF1, 8'hF2);
    push_exp(8'h55, 8'h66, 8'd4, 8'hF1, 8'hF2, 4);
    push_exp(8'h55, 8'h66, 8'd4, 8'hF1, 8'hF2, 9);
    n = 0;
    while (!(tx_valid && got_q.size() == 4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("restart_reach", (n < 200), 1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    run_frames(400, 1'b0);
    check_stream("restart");
    chk("restart_rd_done", n_done - base_done, 1);

    // flush while a byte is held
    clear_logs();
    base_done = n_done;
    base_all  = n_all;
    tx_ready  = 1'b0;
    load_page(8'h88, 8'h99, 8'd2, 8'h12, 8'hAA, 8'hBB);
    wait_valid("flush_reach");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_tx_valid", tx_valid, 0);
    chk("flush_done_all_hi", rd_done_all, 1);
    @(negedge clk);
    chk("flush_done_all_lo", rd_done_all, 0);
    chk("flush_busy", busy, 0);
    chk("flush_all_count", n_all - base_all, 1);
    chk("flush_no_rd_done", n_done - base_done, 0);
    chk("flush_no_bytes", got_q.size(), 0);
    tx_ready = 1'b1;

    // two queued pages drain back to back
    clear_logs();
    base_done = n_done;
    load_page(8'hC1, 8'hD1, 8'd1, 8'h11, 8'h91, 8'h92);
    load_page(8'hC2, 8'hD2, 8'd2, 8'h22, 8'h93, 8'h94);
    push_exp(8'hC1, 8'hD1, 8'd1, 8'h91, 8'h92, 6);
    push_exp(8'hC2, 8'hD2, 8'd2, 8'h93, 8'h94, 7);
    run_frames(400, 1'b0);
    check_stream("two");
    chk("two_flag_count", flg_q.size(), 2);
    if (flg_q.size() == 2) begin
      chk("two_flags0", flg_q[0], 8'h11);
      chk("two_flags1", flg_q[1], 8'h22);
    end
    chk("two_rd_done", n_done - base_done, 2);

    // asynchronous reset in the middle of a frame
    tx_ready = 1'b0;
    load_page(8'h3C, 8'h4C, 8'd5, 8'h5C, 8'h6C, 8'h7C);
    wait_valid("areset_reach");
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_tx_valid", tx_valid, 0);
    chk("areset_busy", busy, 0);
    chk("areset_rd_en", rd_en, 0);
    @(negedge clk);
    reset_n  = 1'b1;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("areset_stays_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
